// File: rtl/rotation_ram_arbiter_pkg.sv
// Shared types and constants for the rotation buffer SDRAM arbiter.
// Burst defaults and data width match the scandoubler side.
package rotation_ram_arbiter_pkg;

    localparam int DATA_W     = 16;
    localparam int IDX_W      = 21;
    localparam int CNT_W      = 5;
    localparam int STARVE_W   = 8;
    localparam int DEF_WR_LEN = 16;
    localparam int DEF_RD_LEN = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_BURST,
        ST_GAP
    } state_e;

    function automatic logic [IDX_W-1:0] word_index(
        input logic       frame,
        input logic [9:0] row,
        input logic [9:0] col
    );
        return {frame, row, col};
    endfunction

endpackage

// File: rtl/rotation_ram_arbiter_if.sv
// Scandoubler vidin/vidout streams and the SDRAM burst port.
// master = arbiter side, slave = requesters plus RAM controller.
interface rotation_ram_arbiter_if #(
    parameter int ADDR_W = 24
);
    import rotation_ram_arbiter_pkg::*;

    logic              vidin_req;
    logic              vidin_frame;
    logic [9:0]        vidin_row;
    logic [9:0]        vidin_col;
    logic [DATA_W-1:0] vidin_d;
    logic              vidin_ack;
    logic              vidout_req;
    logic              vidout_frame;
    logic [9:0]        vidout_row;
    logic [9:0]        vidout_col;
    logic [DATA_W-1:0] vidout_d;
    logic              vidout_ack;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;
    logic              rd_starved;

    modport master (
        input  vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
        input  vidout_req, vidout_frame, vidout_row, vidout_col,
        input  ram_rdata, ram_ack,
        output vidin_ack, vidout_d, vidout_ack,
        output ram_req, ram_we, ram_addr, ram_wdata, rd_starved
    );

    modport slave (
        output vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
        output vidout_req, vidout_frame, vidout_row, vidout_col,
        output ram_rdata, ram_ack,
        input  vidin_ack, vidout_d, vidout_ack,
        input  ram_req, ram_we, ram_addr, ram_wdata, rd_starved
    );

endinterface

// File: rtl/rotation_ram_arbiter_addr.sv
// Linear word address: base + {frame,row,col} + burst word count.
// Column overflow carries into row on purpose.
module rotation_ram_arbiter_addr
    import rotation_ram_arbiter_pkg::*;
#(
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic [CNT_W-1:0]  wcnt,
    output logic [ADDR_W-1:0] addr
);

    assign addr = BASE_ADDR + ADDR_W'(idx) + ADDR_W'(wcnt);

endmodule

// File: rtl/rotation_ram_arbiter.sv
// Read-first burst arbiter between rotation capture and display fetch.
// A GAP cycle separates every burst for bus turnaround.
module rotation_ram_arbiter
    import rotation_ram_arbiter_pkg::*;
#(
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                WR_LEN     = DEF_WR_LEN,
    parameter int                RD_LEN     = DEF_RD_LEN,
    parameter int                MAX_RD_RUN = 4
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    rotation_ram_arbiter_if.master bus
);

    localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic [RUN_W-1:0]    rd_run_q, rd_run_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                starved_q, starved_d;
    logic                vidout_ack_q, vidout_ack_d;
    logic [DATA_W-1:0]   vidout_d_q, vidout_d_d;

    logic                in_burst;
    logic                rd_wins;
    logic [CNT_W-1:0]    last_word;
    logic [ADDR_W-1:0]   addr_w;

    assign in_burst  = (state_q == ST_WR_BURST) ||
                       (state_q == ST_RD_BURST);
    assign last_word = (state_q == ST_WR_BURST) ?
                       CNT_W'(WR_LEN - 1) : CNT_W'(RD_LEN - 1);
    // A pending write only overrides reads once the read run is used up.
    assign rd_wins   = bus.vidout_req &&
                       !(bus.vidin_req &&
                         rd_run_q == RUN_W'(MAX_RD_RUN));

    rotation_ram_arbiter_addr #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr (
        .idx  (idx_q),
        .wcnt (wcnt_q),
        .addr (addr_w)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wcnt_d       = wcnt_q;
        rd_run_d     = rd_run_q;
        starve_d     = starve_q;
        vidout_ack_d = 1'b0;
        vidout_d_d   = vidout_d_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rd_wins) begin
                    state_d = ST_RD_BURST;
                    idx_d   = word_index(bus.vidout_frame,
                                         bus.vidout_row,
                                         bus.vidout_col);
                    if (bus.vidin_req)
                        rd_run_d = rd_run_q + 1'b1;
                end else if (bus.vidin_req) begin
                    state_d  = ST_WR_BURST;
                    idx_d    = word_index(bus.vidin_frame,
                                          bus.vidin_row,
                                          bus.vidin_col);
                    rd_run_d = '0;
                end
            end
            ST_WR_BURST, ST_RD_BURST: begin
                if (bus.ram_ack) begin
                    if (wcnt_q == last_word) begin
                        wcnt_d  = '0;
                        state_d = ST_GAP;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_RD_BURST && bus.ram_ack) begin
            vidout_ack_d = 1'b1;
            vidout_d_d   = bus.ram_rdata;
        end

        if (state_q == ST_IDLE && state_d == ST_RD_BURST)
            starve_d = '0;
        else if (bus.vidout_req && state_q != ST_RD_BURST &&
                 starve_q != '1)
            starve_d = starve_q + 1'b1;

        starved_d = starved_q ||
                    (starve_q > STARVE_W'(WR_LEN + 4));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            wcnt_q       <= '0;
            rd_run_q     <= '0;
            starve_q     <= '0;
            starved_q    <= 1'b0;
            vidout_ack_q <= 1'b0;
            vidout_d_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wcnt_q       <= wcnt_d;
            rd_run_q     <= rd_run_d;
            starve_q     <= starve_d;
            starved_q    <= starved_d;
            vidout_ack_q <= vidout_ack_d;
            vidout_d_q   <= vidout_d_d;
        end
    end

    assign bus.ram_req    = in_burst;
    assign bus.ram_we     = (state_q == ST_WR_BURST);
    assign bus.ram_addr   = in_burst ? addr_w : '0;
    assign bus.ram_wdata  = bus.vidin_d;
    assign bus.vidin_ack  = (state_q == ST_WR_BURST) && bus.ram_ack;
    assign bus.vidout_ack = vidout_ack_q;
    assign bus.vidout_d   = vidout_d_q;
    assign bus.rd_starved = starved_q;

endmodule
